// File: rtl/spi_regbridge_pkg.sv
// Shared types and constants for the SPI-to-register-bus endpoint.
package spi_regbridge_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        WRITE,
        READ
    } state_e;

    localparam int         CMD_WRITE_BIT  = 7;
    localparam logic [7:0] PAD_BYTE       = 8'h00;
    localparam int         STATUS_OVR_BIT = 7;
    localparam int         SO_LATENCY     = 2;

    function automatic logic [7:0] status_byte(input logic ovr, input logic [3:0] id);
        logic [7:0] b;
        b = {4'h0, id};
        b[STATUS_OVR_BIT] = ovr;
        return b;
    endfunction

endpackage

// File: rtl/spi_regbridge_busreq.sv
// Single-outstanding valid/ready request holder; requests arriving while busy are
// dropped and flagged, and the ready cycle produces a completion pulse.
module spi_regbridge_busreq #(
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_i,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [7:0]        req_wdata_i,
    input  logic              bus_ready_i,
    output logic              bus_valid_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [7:0]        bus_wdata_o,
    output logic              drop_o,
    output logic              cpl_o,
    output logic              cpl_we_o
);

    logic              valid_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        wdata_q;

    // Busy through the ready cycle itself, so a same-cycle request is also dropped.
    assign drop_o      = req_i & valid_q;
    assign cpl_o       = valid_q & bus_ready_i;
    assign cpl_we_o    = we_q;
    assign bus_valid_o = valid_q;
    assign bus_we_o    = we_q;
    assign bus_addr_o  = addr_q;
    assign bus_wdata_o = wdata_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 8'h00;
        end else if (req_i && !valid_q) begin
            valid_q <= 1'b1;
            we_q    <= req_we_i;
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
        end else if (cpl_o) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/spi_regbridge_ep.sv
// SPI endpoint: command byte then auto-incrementing burst of register-bus
// writes (MOSI bytes) or reads (returned on subsequent MISO bytes).
module spi_regbridge_ep
    import spi_regbridge_pkg::*;
#(
    parameter int         ADDR_W    = 7,
    parameter logic [3:0] DEVICE_ID = 4'h1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sel,
    input  logic              spi_ctrl_si,
    input  logic              spi_ctrl_so,
    input  logic              spi_ctrl_hd,
    input  logic [7:0]        spi_ctrl_di,
    output logic [7:0]        spi_ctrl_do,
    output logic              bus_valid,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [7:0]        bus_wdata,
    input  logic [7:0]        bus_rdata,
    input  logic              bus_ready
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, req_addr;
    logic [1:0]        so_cnt_q, so_idx, lat_q;
    logic              ovr_q, discard_q;
    logic [7:0]        do_q;
    logic              cmd_hit, so_hdr, req, req_we;
    logic              drop, cpl, cpl_we, rd_cpl;

    assign spi_ctrl_do = do_q;
    assign rd_cpl      = cpl & ~cpl_we;

    // An so arriving with the command si belongs to the next byte, not the header,
    // so it continues the index sequence and sees the freshly decoded state.
    always_comb begin
        cmd_hit  = sel & spi_ctrl_si & spi_ctrl_hd;
        so_hdr   = sel & spi_ctrl_so & spi_ctrl_hd & ~spi_ctrl_si;
        so_idx   = so_hdr ? 2'd0 : so_cnt_q;
        state_d  = state_q;
        addr_d   = addr_q;
        req      = 1'b0;
        req_we   = 1'b0;
        req_addr = addr_q;
        if (cmd_hit) begin
            state_d = spi_ctrl_di[CMD_WRITE_BIT] ? WRITE : READ;
            addr_d  = spi_ctrl_di[ADDR_W-1:0];
        end else if (sel && spi_ctrl_si && !spi_ctrl_hd && state_q == WRITE) begin
            req    = 1'b1;
            req_we = 1'b1;
            addr_d = addr_q + 1'b1;
        end
        if (so_hdr) begin
            state_d = CMD;
        end else if (sel && spi_ctrl_so && so_idx[1] && state_d == READ) begin
            req      = 1'b1;
            req_addr = addr_d;
            addr_d   = addr_d + 1'b1;
        end
        if (!sel) state_d = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            so_cnt_q  <= 2'd0;
            ovr_q     <= 1'b0;
            do_q      <= PAD_BYTE;
            lat_q     <= 2'd0;
            discard_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            if (lat_q != 2'd3) lat_q <= lat_q + 2'd1;
            if (!sel) begin
                so_cnt_q <= 2'd0;
                if (bus_valid && !bus_we && !cpl) discard_q <= 1'b1;
            end else if (spi_ctrl_so) begin
                so_cnt_q <= (so_idx == 2'd3) ? so_idx : so_idx + 2'd1;
                if (so_idx == 2'd0) begin
                    do_q  <= status_byte(ovr_q, DEVICE_ID);
                    ovr_q <= 1'b0;
                end else if (so_idx == 2'd1 || state_d != READ) begin
                    do_q <= PAD_BYTE;
                end
            end
            if (req && !req_we && !bus_valid) lat_q <= 2'd0;
            if (drop) ovr_q <= 1'b1;
            if (rd_cpl) begin
                if (discard_q || !sel) begin
                    discard_q <= 1'b0;
                end else begin
                    do_q <= bus_rdata;
                    if (lat_q >= 2'(SO_LATENCY)) ovr_q <= 1'b1;
                end
            end
        end
    end

    spi_regbridge_busreq #(
        .ADDR_W(ADDR_W)
    ) u_busreq (
        .clk        (clk),
        .reset      (reset),
        .req_i      (req),
        .req_we_i   (req_we),
        .req_addr_i (req_addr),
        .req_wdata_i(spi_ctrl_di),
        .bus_ready_i(bus_ready),
        .bus_valid_o(bus_valid),
        .bus_we_o   (bus_we),
        .bus_addr_o (bus_addr),
        .bus_wdata_o(bus_wdata),
        .drop_o     (drop),
        .cpl_o      (cpl),
        .cpl_we_o   (cpl_we)
    );

endmodule

// File: tb/tb_spi_regbridge_ep.sv
// Directed bench for spi_regbridge_ep: status byte, write/read bursts, wrap,
// stalled read overrun, sel drop and asynchronous reset.
module tb_spi_regbridge_ep;

    logic       clk = 1'b0;
    logic       reset, sel, si, so, hd;
    logic [7:0] di, sdo, rdata, wdata;
    logic       valid, we, ready, auto_rdy, man_rdy;
    logic [6:0] addr;
    int         tests = 0;
    int         fails = 0;
    int         nw = 0;
    logic [6:0] wa [8];
    logic [7:0] wd [8];

    always #5 clk = ~clk;

    assign ready = auto_rdy ? valid : man_rdy;
    assign rdata = {1'b0, addr} ^ 8'hFF;

    spi_regbridge_ep #(.ADDR_W(7), .DEVICE_ID(4'h1)) dut (
        .clk        (clk),
        .reset      (reset),
        .sel        (sel),
        .spi_ctrl_si(si),
        .spi_ctrl_so(so),
        .spi_ctrl_hd(hd),
        .spi_ctrl_di(di),
        .spi_ctrl_do(sdo),
        .bus_valid  (valid),
        .bus_we     (we),
        .bus_addr   (addr),
        .bus_wdata  (wdata),
        .bus_rdata  (rdata),
        .bus_ready  (ready)
    );

    always @(posedge clk) begin
        if (valid && ready && we && nw < 8) begin
            wa[nw] <= addr;
            wd[nw] <= wdata;
            nw     <= nw + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input logic s_i, input logic s_o, input logic h, input logic [7:0] d);
        si = s_i; so = s_o; hd = h; di = d;
        tick();
        si = 1'b0; so = 1'b0; hd = 1'b0;
    endtask

    initial begin
        reset = 1'b1; sel = 1'b0; si = 1'b0; so = 1'b0; hd = 1'b0; di = 8'h00;
        auto_rdy = 1'b0; man_rdy = 1'b0;
        tick(); tick();
        chk("rst_do",    sdo, 8'h00);
        chk("rst_valid", {7'b0, valid}, 8'h00);
        chk("rst_we",    {7'b0, we}, 8'h00);
        chk("rst_addr",  {1'b0, addr}, 8'h00);
        chk("rst_wdata", wdata, 8'h00);
        reset = 1'b0;
        tick();

        // status byte then pad
        sel = 1'b1;
        strobe(1'b0, 1'b1, 1'b1, 8'h00); chk("status", sdo, 8'h01);
        strobe(1'b0, 1'b1, 1'b0, 8'h00); chk("pad1", sdo, 8'h00);

        // write burst at 0x05
        auto_rdy = 1'b1; sel = 1'b0; tick(); sel = 1'b1;
        strobe(1'b0, 1'b1, 1'b1, 8'h00);
        strobe(1'b1, 1'b1, 1'b1, 8'h85);
        strobe(1'b1, 1'b0, 1'b0, 8'hAA);
        chk("wr0_valid", {7'b0, valid}, 8'h01);
        chk("wr0_we",    {7'b0, we}, 8'h01);
        chk("wr0_addr",  {1'b0, addr}, 8'h05);
        chk("wr0_data",  wdata, 8'hAA);
        tick(); chk("wr0_vdrop", {7'b0, valid}, 8'h00);
        strobe(1'b1, 1'b0, 1'b0, 8'hBB);
        chk("wr1_addr",  {1'b0, addr}, 8'h06);
        chk("wr1_data",  wdata, 8'hBB);
        tick(); chk("wr1_vdrop", {7'b0, valid}, 8'h00);

        // read burst at 0x10, command si together with index-2 so
        sel = 1'b0; tick(); sel = 1'b1;
        strobe(1'b0, 1'b1, 1'b1, 8'h00);
        strobe(1'b0, 1'b1, 1'b0, 8'h00);
        strobe(1'b1, 1'b1, 1'b1, 8'h10);
        chk("rd0_addr", {1'b0, addr}, 8'h10);
        chk("rd0_we",   {7'b0, we}, 8'h00);
        chk("rd0_hold", sdo, 8'h00);
        tick(); chk("rd0_do", sdo, 8'hEF);
        strobe(1'b0, 1'b1, 1'b0, 8'h00); tick(); chk("rd1_do", sdo, 8'hEE);
        strobe(1'b0, 1'b1, 1'b0, 8'h00); tick(); chk("rd2_do", sdo, 8'hED);

        // address wrap
        sel = 1'b0; tick(); sel = 1'b1;
        strobe(1'b0, 1'b1, 1'b1, 8'h00); chk("wrap_status", sdo, 8'h01);
        strobe(1'b1, 1'b1, 1'b1, 8'hFF);
        strobe(1'b1, 1'b0, 1'b0, 8'h11); chk("wrap0_addr", {1'b0, addr}, 8'h7F);
        tick();
        strobe(1'b1, 1'b0, 1'b0, 8'h22); chk("wrap1_addr", {1'b0, addr}, 8'h00);
        tick();

        // stalled read sets ovr
        auto_rdy = 1'b0; sel = 1'b0; tick(); sel = 1'b1;
        strobe(1'b0, 1'b1, 1'b1, 8'h00);
        strobe(1'b0, 1'b1, 1'b0, 8'h00);
        strobe(1'b1, 1'b1, 1'b1, 8'h20);
        repeat (20) tick();
        chk("stall_valid", {7'b0, valid}, 8'h01);
        chk("stall_addr",  {1'b0, addr}, 8'h20);
        chk("stall_do",    sdo, 8'h00);
        man_rdy = 1'b1; tick(); man_rdy = 1'b0;
        chk("stall_cpl",   sdo, 8'hDF);
        chk("stall_vdrop", {7'b0, valid}, 8'h00);
        sel = 1'b0; tick(); sel = 1'b1;
        strobe(1'b0, 1'b1, 1'b1, 8'h00); chk("ovr_status", sdo, 8'h81);
        sel = 1'b0; tick(); sel = 1'b1;
        strobe(1'b0, 1'b1, 1'b1, 8'h00); chk("ovr_clear", sdo, 8'h01);

        // sel dropped while a read is stalled
        sel = 1'b0; tick(); sel = 1'b1;
        strobe(1'b0, 1'b1, 1'b1, 8'h00);
        strobe(1'b0, 1'b1, 1'b0, 8'h00);
        strobe(1'b1, 1'b1, 1'b1, 8'h30);
        tick(); sel = 1'b0; repeat (3) tick();
        chk("seloff_valid", {7'b0, valid}, 8'h01);
        chk("seloff_addr",  {1'b0, addr}, 8'h30);
        man_rdy = 1'b1; tick(); man_rdy = 1'b0;
        chk("seloff_do",    sdo, 8'h00);
        chk("seloff_vdrop", {7'b0, valid}, 8'h00);

        // asynchronous reset mid-burst
        auto_rdy = 1'b1; sel = 1'b1;
        strobe(1'b0, 1'b1, 1'b1, 8'h00);
        strobe(1'b0, 1'b1, 1'b0, 8'h00);
        strobe(1'b1, 1'b1, 1'b1, 8'h40);
        tick(); chk("arst_pre_do", sdo, 8'hBF);
        auto_rdy = 1'b0;
        strobe(1'b0, 1'b1, 1'b0, 8'h00);
        chk("arst_pend", {7'b0, valid}, 8'h01);
        #2 reset = 1'b1;
        #1;
        chk("arst_valid", {7'b0, valid}, 8'h00);
        chk("arst_do",    sdo, 8'h00);
        chk("arst_addr",  {1'b0, addr}, 8'h00);
        tick(); reset = 1'b0;
        tick();

        chk("wr_count", 8'(nw), 8'h04);
        chk("wr2_addr", {1'b0, wa[2]}, 8'h7F);
        chk("wr3_addr", {1'b0, wa[3]}, 8'h00);
        chk("wr0_log",  wd[0], 8'hAA);
        chk("wr3_log",  wd[3], 8'h22);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
